// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: FSM states, write-data
// select encodings and the default memory-load timeout.
package wb_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wbState_t;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/wb_stage_if.sv
// Write-back stage bus: MEM/WB bundle in, data-memory response in,
// stall back upstream, register-file write port and its forwarding copy out.
// Optional WB_RETIRE_CNT_EN adds the retire_count output.
interface wb_stage_if #(
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned REG_ADDR_W  = 3
);
  logic                   in_valid;
  logic [REG_ADDR_W-1:0]  in_dest;
  logic                   in_regWrite;
  logic                   in_wbSel;
  logic                   in_LDM;
  logic [WORD_LENGTH-1:0] in_aluResult;
  logic [WORD_LENGTH-1:0] mem_rdata;
  logic                   mem_rvalid;
  logic                   stall;
  logic                   regWrite;
  logic [REG_ADDR_W-1:0]  writeAddress;
  logic [WORD_LENGTH-1:0] regFileWriteData;
  logic                   fwd_valid;
  logic [REG_ADDR_W-1:0]  fwd_addr;
  logic [WORD_LENGTH-1:0] fwd_data;
  logic                   mem_timeout_err;
`ifdef WB_RETIRE_CNT_EN
  logic [15:0]            retire_count;
`endif

  modport master (
`ifdef WB_RETIRE_CNT_EN
    input  retire_count,
`endif
    output in_valid, in_dest, in_regWrite, in_wbSel, in_LDM, in_aluResult,
    output mem_rdata, mem_rvalid,
    input  stall, regWrite, writeAddress, regFileWriteData,
    input  fwd_valid, fwd_addr, fwd_data, mem_timeout_err
  );

  modport slave (
`ifdef WB_RETIRE_CNT_EN
    output retire_count,
`endif
    input  in_valid, in_dest, in_regWrite, in_wbSel, in_LDM, in_aluResult,
    input  mem_rdata, mem_rvalid,
    output stall, regWrite, writeAddress, regFileWriteData,
    output fwd_valid, fwd_addr, fwd_data, mem_timeout_err
  );
endinterface

// File: rtl/wb_timeout_counter.sv
// Clearable, enabled, saturating up-counter. done flags the enabled cycle
// whose increment reaches LIMIT, so the owner can leave on that same edge.
module wb_timeout_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);
  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] LAST_W  = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  // Count enabled cycles, holding at LIMIT instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT_W)) begin
      count <= count + 1'b1;
    end
  end

  assign done = enable && (count >= LAST_W);
endmodule

// File: rtl/wb_stage.sv
// Write-back stage: latches the MEM/WB bundle, drives the register-file
// write port plus its forwarding mirror, and parks in WAIT_MEM for loads
// until data returns or the timeout fires.
// Optional feature macro: WB_RETIRE_CNT_EN (adds retire_count).
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned REG_ADDR_W  = 3,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input logic       clk,
  input logic       rst,
  wb_stage_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  wbState_t               state;
  logic                   stall_p1;
  logic                   wrEn_p1;
  logic [REG_ADDR_W-1:0]  wrAddr_p1;
  logic [WORD_LENGTH-1:0] wrData_p1;
  logic [REG_ADDR_W-1:0]  pendDest;
  logic                   pendRegWrite;
  logic                   timeoutErr;
  logic                   loadAccept;
  logic                   aluAccept;
  logic                   memDone;
  logic                   cntDone;

  // Non-load bundles carry no memory data, so the memory leg reads as zero.
  function automatic logic [WORD_LENGTH-1:0] wbMux(
    input logic                   sel,
    input logic [WORD_LENGTH-1:0] alu,
    input logic [WORD_LENGTH-1:0] mem
  );
    logic [WORD_LENGTH-1:0] res;
    res = '0;
    case (sel)
      WB_SEL_ALU: res = alu;
      WB_SEL_MEM: res = mem;
      default:    res = '0;
    endcase
    return res;
  endfunction

  assign loadAccept = (state == IDLE) && bus.in_valid && bus.in_LDM;
  assign aluAccept  = (state == IDLE) && bus.in_valid && !bus.in_LDM;
  assign memDone    = (state == WAIT_MEM) && bus.mem_rvalid;

  wb_timeout_counter #(
    .WIDTH (CNT_W),
    .LIMIT (MEM_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (loadAccept),
    .enable (state == WAIT_MEM),
    .done   (cntDone)
  );

  // Accept/write-back FSM; address and data only move when a write fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      stall_p1     <= 1'b0;
      wrEn_p1      <= 1'b0;
      wrAddr_p1    <= '0;
      wrData_p1    <= '0;
      pendDest     <= '0;
      pendRegWrite <= 1'b0;
      timeoutErr   <= 1'b0;
    end else begin
      wrEn_p1 <= 1'b0;
      case (state)
        IDLE: begin
          if (loadAccept) begin
            pendDest     <= bus.in_dest;
            pendRegWrite <= bus.in_regWrite;
            state        <= WAIT_MEM;
            stall_p1     <= 1'b1;
          end else if (aluAccept && bus.in_regWrite) begin
            wrEn_p1   <= 1'b1;
            wrAddr_p1 <= bus.in_dest;
            wrData_p1 <= wbMux(bus.in_wbSel, bus.in_aluResult, '0);
          end
        end
        WAIT_MEM: begin
          if (bus.mem_rvalid) begin
            if (pendRegWrite) begin
              wrEn_p1   <= 1'b1;
              wrAddr_p1 <= pendDest;
              wrData_p1 <= wbMux(WB_SEL_MEM, '0, bus.mem_rdata);
            end
            state    <= IDLE;
            stall_p1 <= 1'b0;
          end else if (cntDone) begin
            state      <= IDLE;
            stall_p1   <= 1'b0;
            timeoutErr <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          stall_p1 <= 1'b0;
        end
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [15:0] retireCount;

  // Count completed instructions; timed-out loads never complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      retireCount <= '0;
    end else if (aluAccept || memDone) begin
      retireCount <= retireCount + 16'd1;
    end
  end

  assign bus.retire_count = retireCount;
`endif

  assign bus.stall            = stall_p1;
  assign bus.regWrite         = wrEn_p1;
  assign bus.writeAddress     = wrAddr_p1;
  assign bus.regFileWriteData = wrData_p1;
  assign bus.fwd_valid        = wrEn_p1;
  assign bus.fwd_addr         = wrAddr_p1;
  assign bus.fwd_data         = wrData_p1;
  assign bus.mem_timeout_err  = timeoutErr;
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back end of the pipeline; the writer for the register file that the decode stage reads.
- Latches the MEM/WB bundle and selects ALU result or load data.
- Drives the register-file write port (regWrite, writeAddress, regFileWriteData) and mirrors that write on a forwarding bus.
- Multi-cycle data-memory loads are absorbed by a small FSM that stalls upstream until load data returns or a timeout fires.

Parameters:
WORD_LENGTH, 8, data width of ALU result, memory read data and register-file write data
REG_ADDR_W, 3, register address width (8 registers)
MEM_TIMEOUT, 15, max cycles spent in WAIT_MEM before the load is abandoned (1..255)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  MEM/WB bundle valid this cycle
in_dest  input  REG_ADDR_W  destination register
in_regWrite  input  1  instruction writes the register file
in_wbSel  input  1  write-data select: 0 = ALU result, 1 = memory data
in_LDM  input  1  instruction is a load; wait for mem_rvalid
in_aluResult  input  WORD_LENGTH  ALU result
mem_rdata  input  WORD_LENGTH  data-memory read data
mem_rvalid  input  1  mem_rdata valid this cycle
stall  output  1  upstream must hold its bundle
regWrite  output  1  register-file write enable (one-cycle pulse)
writeAddress  output  REG_ADDR_W  register-file write address
regFileWriteData  output  WORD_LENGTH  register-file write data
fwd_valid, fwd_addr, fwd_data  output  1/REG_ADDR_W/WORD_LENGTH  forwarding copy of the write port
mem_timeout_err  output  1  sticky: a load timed out

Behaviour:
- States: IDLE, WAIT_MEM.
- Reset: state IDLE; all outputs 0; timeout counter 0; mem_timeout_err 0.
- Reset mid-WAIT_MEM discards the pending load. Any later mem_rvalid is ignored.
- Accept: bundle accepted when in_valid=1 and state=IDLE. stall = (state==WAIT_MEM), registered.
- Non-load accepted at edge N:
  - Cycle after N: regWrite = in_regWrite, writeAddress = in_dest.
  - regFileWriteData = in_aluResult when in_wbSel=0. When in_wbSel=1 without LDM it is 0; controller never issues this.
  - Latency 1. Back-to-back accepts give back-to-back write pulses.
- Load accepted at edge N:
  - Latch dest/regWrite. Go to WAIT_MEM; stall=1 from cycle N+1.
  - Counter cleared, then increments each WAIT_MEM cycle.
- In WAIT_MEM with mem_rvalid=1 at edge M:
  - Capture mem_rdata.
  - Cycle M+1: regWrite = latched regWrite, data = captured mem_rdata, state IDLE, stall=0.
- Timeout: counter reaching MEM_TIMEOUT without mem_rvalid returns to IDLE with no write and sets mem_timeout_err=1 until rst.
- mem_rvalid and timeout on the same edge: data wins, no error.
- A load arriving with mem_rvalid=1 in its own accept cycle still waits for a subsequent mem_rvalid. Memory data is never earlier than N+1.
- in_valid while stall=1 is ignored; upstream holds.
- mem_rvalid in IDLE is ignored.
- in_regWrite=0 loads still stall until completion. They produce no write pulse.
- Outputs hold their last address/data when regWrite=0. fwd_* equal the write outputs exactly, same cycle.
- All arithmetic unsigned. The counter saturates at MEM_TIMEOUT and does not wrap.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- When defined:
  - Adds output retire_count[15:0], reset to 0.
  - Increments once per completed instruction (non-load accept, or load completion with data, regardless of regWrite).
  - Timed-out loads do not count. Wraps 0xFFFF -> 0.
- When undefined: port and counter absent; otherwise identical behaviour.

Decomposition:
- Shared package wb_pkg holds:
  - State typedef (IDLE, WAIT_MEM).
  - WB_SEL_ALU=1'b0 and WB_SEL_MEM=1'b1 constants.
  - Default MEM_TIMEOUT.
- One sub-module, wb_timeout_counter: clear/enable/saturating counter with a done flag, parameterised by width and limit.

Test Plan:
- ALU write:
  - Stimulus: in_valid=1, in_dest=3, in_regWrite=1, in_wbSel=0, in_aluResult=8'h5A.
  - Response: next cycle regWrite=1, writeAddress=3, data=8'h5A, fwd_* identical; following cycle regWrite=0.
- Load, latency 3:
  - Stimulus: load to r5; mem_rvalid=1 with 8'hC3 three cycles later.
  - Response: stall=1 for exactly those cycles; then regWrite=1, address 5, data 8'hC3; stall=0.
- Timeout:
  - Stimulus: load to r2; mem_rvalid never asserted.
  - Response: after 15 WAIT_MEM cycles state IDLE, no write pulse, mem_timeout_err=1 and stays 1; a following ALU write to r1 completes normally.
- Reset mid-load:
  - Stimulus: rst=1 during WAIT_MEM, then mem_rvalid=1 with 8'hFF after reset.
  - Response: all outputs 0, stall=0, no write of 8'hFF.
- Back-to-back:
  - Stimulus: four consecutive ALU writes r0..r3, data 1..4, then in_regWrite=0 bundle.
  - Response: four consecutive write pulses with matching address/data, then regWrite=0.
  - With WB_RETIRE_CNT_EN: retire_count=5.
- Edge case:
  - Stimulus: mem_rvalid and counter limit on the same edge with data 8'h11.
  - Response: write of 8'h11, mem_timeout_err stays 0.
